// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, phase FSMs, registered syncs.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt_o counter.
module vga_timing #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pix_en_i,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        active_o,
   output logic [9:0]  x_o,
   output logic [9:0]  y_o,
   output logic        line_start_o,
   output logic        frame_start_o
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt_o
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_FP_X = 10'(H_ACTIVE);
   localparam logic [9:0] H_SY_X = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_X = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);

   localparam logic [9:0] V_FP_Y = 10'(V_ACTIVE);
   localparam logic [9:0] V_SY_Y = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BP_Y = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   localparam logic [1:0] PH_ACT  = 2'd0;
   localparam logic [1:0] PH_FP   = 2'd1;
   localparam logic [1:0] PH_SYNC = 2'd2;
   localparam logic [1:0] PH_BP   = 2'd3;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   // Zero-width phases are skipped so their boundary never overrides the next.
   function automatic logic [1:0] h_phase(input logic [9:0] x,
                                          input logic [1:0] cur);
      h_phase = cur;
      if (H_BP > 0 && x == H_BP_X)
         h_phase = PH_BP;
      else if (H_SYNC > 0 && x == H_SY_X)
         h_phase = PH_SYNC;
      else if (H_FP > 0 && x == H_FP_X)
         h_phase = PH_FP;
      else if (x == 10'd0)
         h_phase = PH_ACT;
   endfunction

   function automatic logic [1:0] v_phase(input logic [9:0] y,
                                          input logic [1:0] cur);
      v_phase = cur;
      if (V_BP > 0 && y == V_BP_Y)
         v_phase = PH_BP;
      else if (V_SYNC > 0 && y == V_SY_Y)
         v_phase = PH_SYNC;
      else if (V_FP > 0 && y == V_FP_Y)
         v_phase = PH_FP;
      else if (y == 10'd0)
         v_phase = PH_ACT;
   endfunction

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic [1:0] hph_q, hph_d;
   logic [1:0] vph_q, vph_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       active_q, active_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   // Outputs are computed from the next position so they register in step.
   always_comb begin
      x_d           = x_q;
      y_d           = y_q;
      hph_d         = hph_q;
      vph_d         = vph_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      active_d      = active_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_en_i) begin
         if (x_q == H_LAST) begin
            x_d          = '0;
            line_start_d = 1'b1;
            if (y_q == V_LAST) begin
               y_d           = '0;
               frame_start_d = 1'b1;
            end else begin
               y_d = y_q + 10'd1;
            end
            vph_d = v_phase(y_d, vph_q);
         end else begin
            x_d = x_q + 10'd1;
         end
         hph_d    = h_phase(x_d, hph_q);
         hsync_d  = (hph_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         vsync_d  = (vph_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         active_d = (hph_d == PH_ACT) && (vph_d == PH_ACT);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q           <= '0;
         y_q           <= '0;
         hph_q         <= PH_ACT;
         vph_q         <= PH_ACT;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         active_q      <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hph_q         <= hph_d;
         vph_q         <= vph_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign active_o      = active_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q + 16'(frame_start_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         frame_cnt_q <= '0;
      else
         frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default-timing instance plus a
// short-line, active-high-sync instance for frame-level behaviour.
module tb_vga_timing;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, pe_a, hs_a, vs_a, act_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       rst_b, pe_b, hs_b, vs_b, act_b, ls_b, fs_b;
   logic [9:0] x_b, y_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fc_a, fc_b;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   vga_timing dut_a (
      .clk_i        (clk),
      .rst_ni       (rst_a),
      .pix_en_i     (pe_a),
      .hsync_o      (hs_a),
      .vsync_o      (vs_a),
      .active_o     (act_a),
      .x_o          (x_a),
      .y_o          (y_a),
      .line_start_o (ls_a),
      .frame_start_o(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt_o  (fc_a)
`endif
   );

   // 24-pixel lines keep a full 525-line frame short.
   vga_timing #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .SYNC_POL(1'b1)
   ) dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_b),
      .pix_en_i     (pe_b),
      .hsync_o      (hs_b),
      .vsync_o      (vs_b),
      .active_o     (act_b),
      .x_o          (x_b),
      .y_o          (y_b),
      .line_start_o (ls_b),
      .frame_start_o(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt_o  (fc_b)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs_lo, hs_first, hs_last, ls_cnt, ls_pos, ls_pos2, x_err;
      int act639, act640, y800;
      int en_cnt, hold_err, xm_err, ls_first, ls_last;
      int prev_x;
      int vs_cnt, vs_y0, vs_y1, hs_cnt, act_cnt, act480, fs_cnt, fs_pos;

      rst_a = 1'b0; pe_a = 1'b0;
      rst_b = 1'b0; pe_b = 1'b0;
      act639 = 0; act640 = 0; y800 = 0;
      tick();
      tick();

      chk("rst_x", int'(x_a), 0);
      chk("rst_y", int'(y_a), 0);
      chk("rst_hsync", int'(hs_a), 1);
      chk("rst_vsync", int'(vs_a), 1);
      chk("rst_active", int'(act_a), 1);
      chk("rst_pulses", int'({ls_a, fs_a}), 0);
      chk("rst_b_syncs", int'({hs_b, vs_b}), 0);
      chk("rst_b_active", int'(act_b), 1);

      rst_a = 1'b1;
      rst_b = 1'b1;
      pe_a  = 1'b1;
      tick();
      chk("first_x", int'(x_a), 1);
      chk("first_y", int'(y_a), 0);
      chk("first_ls", int'(ls_a), 0);

      hs_lo = 0; hs_first = -1; hs_last = -1;
      ls_cnt = 0; ls_pos = 0; x_err = 0;
      for (int j = 2; j <= 800; j++) begin
         tick();
         if (x_a != 10'(j % 800)) x_err++;
         if (!hs_a) begin
            hs_lo++;
            if (hs_first < 0) hs_first = int'(x_a);
            hs_last = int'(x_a);
         end
         if (ls_a) begin
            ls_cnt++;
            ls_pos = j;
         end
         if (j == 639) act639 = int'(act_a);
         if (j == 640) act640 = int'(act_a);
         if (j == 800) y800 = int'(y_a);
      end
      chk("line_x_seq", x_err, 0);
      chk("hsync_low_cnt", hs_lo, 96);
      chk("hsync_first_x", hs_first, 656);
      chk("hsync_last_x", hs_last, 751);
      chk("line1_ls_cnt", ls_cnt, 1);
      chk("line1_ls_pos", ls_pos, 800);
      chk("y_after_wrap", y800, 1);
      chk("active_x639", act639, 1);
      chk("active_x640", act640, 0);
      chk("fs_not_line", int'(fs_a), 0);

      ls_cnt = 0; ls_pos2 = 0;
      for (int j = 801; j <= 1600; j++) begin
         tick();
         if (ls_a) begin
            ls_cnt++;
            ls_pos2 = j;
         end
      end
      chk("line2_ls_cnt", ls_cnt, 1);
      chk("ls_period", ls_pos2 - ls_pos, 800);
      chk("line2_y", int'(y_a), 2);

      en_cnt = 0; hold_err = 0; xm_err = 0;
      ls_cnt = 0; ls_first = -1; ls_last = -1;
      for (int k = 0; k < 3200; k++) begin
         pe_a   = (k % 2 == 0);
         prev_x = int'(x_a);
         tick();
         if (pe_a) en_cnt++;
         else if (int'(x_a) != prev_x || ls_a) hold_err++;
         if (x_a != 10'(en_cnt % 800)) xm_err++;
         if (ls_a) begin
            ls_cnt++;
            if (ls_first < 0) ls_first = k;
            ls_last = k;
         end
      end
      chk("half_x_model", xm_err, 0);
      chk("half_hold", hold_err, 0);
      chk("half_ls_cnt", ls_cnt, 2);
      chk("half_ls_period", ls_last - ls_first, 1600);
      chk("half_y", int'(y_a), 4);

      pe_a = 1'b1;
      for (int j = 0; j < 300; j++) tick();
      chk("pre_rst_x", int'(x_a), 300);
      chk("pre_rst_y", int'(y_a), 4);
      rst_a = 1'b0;
      #2;
      chk("async_rst_x", int'(x_a), 0);
      chk("async_rst_y", int'(y_a), 0);
      chk("async_rst_act", int'(act_a), 1);
      tick();
      tick();
      chk("held_rst_x", int'(x_a), 0);
      rst_a = 1'b1;
      tick();
      chk("post_rst_x", int'(x_a), 1);
      chk("post_rst_y", int'(y_a), 0);
      chk("post_rst_ls", int'(ls_a), 0);
      pe_a = 1'b0;

      vs_cnt = 0; vs_y0 = -1; vs_y1 = -1; hs_cnt = 0;
      act_cnt = 0; act480 = 0; ls_cnt = 0; fs_cnt = 0; fs_pos = 0;
      pe_b = 1'b1;
      for (int j = 1; j <= 12600; j++) begin
         tick();
         if (vs_b) begin
            vs_cnt++;
            if (vs_y0 < 0) vs_y0 = int'(y_b);
            vs_y1 = int'(y_b);
         end
         if (hs_b) hs_cnt++;
         if (act_b) begin
            act_cnt++;
            if (y_b == 10'd480) act480++;
         end
         if (ls_b) ls_cnt++;
         if (fs_b) begin
            fs_cnt++;
            fs_pos = j;
         end
      end
      chk("b_vsync_cnt", vs_cnt, 48);
      chk("b_vsync_y0", vs_y0, 490);
      chk("b_vsync_y1", vs_y1, 491);
      chk("b_hsync_hi_cnt", hs_cnt, 2100);
      chk("b_active_cnt", act_cnt, 7680);
      chk("b_active_y480", act480, 0);
      chk("b_ls_cnt", ls_cnt, 525);
      chk("b_fs_cnt", fs_cnt, 1);
      chk("b_fs_pos", fs_pos, 12600);
      chk("b_end_xy", int'({x_b, y_b}), 0);

`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("fc_one", int'(fc_b), 1);
      for (int j = 0; j < 25200; j++) tick();
      chk("fc_three", int'(fc_b), 3);
      chk("fc_a_idle", int'(fc_a), 0);
      force dut_b.frame_cnt_q = 16'hFFFF;
      #1;
      release dut_b.frame_cnt_q;
      chk("fc_preload", int'(fc_b), 65535);
      for (int j = 0; j < 12600; j++) tick();
      chk("fc_wrap", int'(fc_b), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
